// File: rtl/beat_pkg.sv
// Shared types and default sizing for the multi-channel beat generator.
package beat_pkg;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned WIDTH_DEF          = 22;
  localparam int unsigned NCH_DEF            = 4;
  localparam int unsigned DEFAULT_PERIOD_DEF = 3125000;

endpackage

// File: rtl/beat_chan.sv
// One beat channel: IDLE/RUN FSM, period counter, shadow and active period/mode.
module beat_chan
  import beat_pkg::*;
#(
  parameter int unsigned WIDTH          = WIDTH_DEF,
  parameter int unsigned DEFAULT_PERIOD = DEFAULT_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic             sync,
  input  logic             load,
  input  logic [WIDTH-1:0] load_period,
  input  logic             load_mode,
  output logic             tick,
  output logic             running
);

  state_e           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] act_period;
  logic [WIDTH-1:0] sh_period;
  mode_e            act_mode;
  mode_e            sh_mode;

  logic [WIDTH-1:0] nxt_period;
  mode_e            nxt_mode;
  logic             wrap;
  logic             launch;

  // Shadow contents as they will be after this edge, so a load coincident
  // with a wrap or sync governs the following period.
  always_comb begin
    nxt_period = load ? load_period : sh_period;
    nxt_mode   = load ? mode_e'(load_mode) : sh_mode;
    wrap       = (act_period != '0) && (cnt == act_period - WIDTH'(1));
    launch     = en && (nxt_period != '0) &&
                 ((nxt_mode == MODE_PERIODIC) || start);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      tick       <= 1'b0;
      act_period <= WIDTH'(DEFAULT_PERIOD);
      sh_period  <= WIDTH'(DEFAULT_PERIOD);
      act_mode   <= MODE_PERIODIC;
      sh_mode    <= MODE_PERIODIC;
    end else begin
      tick <= 1'b0;
      if (load) begin
        sh_period <= load_period;
        sh_mode   <= mode_e'(load_mode);
      end
      case (state)
        ST_IDLE: begin
          // An idle channel's active settings simply track the shadow.
          act_period <= nxt_period;
          act_mode   <= nxt_mode;
          cnt        <= '0;
          if (launch) state <= ST_RUN;
        end
        ST_RUN: begin
          if (!en) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (sync) begin
            cnt        <= '0;
            act_period <= nxt_period;
            act_mode   <= nxt_mode;
            if (nxt_period == '0) state <= ST_IDLE;
          end else if ((act_mode == MODE_ONESHOT) && start) begin
            cnt <= '0;
          end else if (wrap) begin
            cnt        <= '0;
            tick       <= 1'b1;
            act_period <= nxt_period;
            act_mode   <= nxt_mode;
            if ((act_mode == MODE_ONESHOT) || (nxt_period == '0)) state <= ST_IDLE;
          end else begin
            cnt <= cnt + WIDTH'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign running = (state == ST_RUN);

endmodule

// File: rtl/beat_gen_multi.sv
// NCH independent beat/tick dividers of the system clock with shared load port and sync.
module beat_gen_multi
  import beat_pkg::*;
#(
  parameter int unsigned WIDTH          = WIDTH_DEF,
  parameter int unsigned NCH            = NCH_DEF,
  parameter int unsigned DEFAULT_PERIOD = DEFAULT_PERIOD_DEF,
  localparam int unsigned CHW           = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   en,
  input  logic [NCH-1:0]   start,
  input  logic             sync,
  input  logic             load_valid,
  input  logic [CHW-1:0]   load_ch,
  input  logic [WIDTH-1:0] load_period,
  input  logic             load_mode,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   running
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic ld;
    assign ld = load_valid && (load_ch == CHW'(i));

    beat_chan #(
      .WIDTH          (WIDTH),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .en          (en[i]),
      .start       (start[i]),
      .sync        (sync),
      .load        (ld),
      .load_period (load_period),
      .load_mode   (load_mode),
      .tick        (tick[i]),
      .running     (running[i])
    );
  end

endmodule

// File: tb/tb_beat_gen_multi.sv
// Directed self-checking bench for beat_gen_multi (WIDTH=8, NCH=2, DEFAULT_PERIOD=5).
module tb_beat_gen_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] en;
  logic [1:0] start;
  logic       sync;
  logic       load_valid;
  logic [0:0] load_ch;
  logic [7:0] load_period;
  logic       load_mode;
  logic [1:0] tick;
  logic [1:0] running;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  beat_gen_multi #(
    .WIDTH          (8),
    .NCH            (2),
    .DEFAULT_PERIOD (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .start       (start),
    .sync        (sync),
    .load_valid  (load_valid),
    .load_ch     (load_ch),
    .load_period (load_period),
    .load_mode   (load_mode),
    .tick        (tick),
    .running     (running)
  );

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    en          = 2'b00;
    start       = 2'b00;
    sync        = 1'b0;
    load_valid  = 1'b0;
    load_ch     = 1'b0;
    load_period = 8'd0;
    load_mode   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (tick !== 2'b00) begin n_err++; $display("FAIL reset_tick got=%b want=00", tick); end
    n_cmp++;
    if (running !== 2'b00) begin n_err++; $display("FAIL reset_running got=%b want=00", running); end
    do_reset();
    cyc();
    n_cmp++;
    if (tick !== 2'b00 || running !== 2'b00) begin
      n_err++; $display("FAIL post_reset_idle tick=%b running=%b want 00/00", tick, running);
    end
  endtask

  task automatic test_periodic();
    logic [1:0] exp;
    do_reset();
    en = 2'b01;
    for (int m = 0; m < 12; m++) begin
      cyc();
      exp = (m > 0 && m % 5 == 0) ? 2'b01 : 2'b00;
      n_cmp++;
      if (tick !== exp) begin n_err++; $display("FAIL periodic_tick m=%0d got=%b want=%b", m, tick, exp); end
      n_cmp++;
      if (running !== 2'b01) begin n_err++; $display("FAIL periodic_running m=%0d got=%b want=01", m, running); end
    end
  endtask

  task automatic test_load_midperiod();
    logic [1:0] exp;
    do_reset();
    en = 2'b01;
    for (int m = 0; m < 16; m++) begin
      load_valid  = (m == 2);
      load_ch     = 1'b0;
      load_period = 8'd3;
      load_mode   = 1'b0;
      cyc();
      exp = (m == 5 || m == 8 || m == 11 || m == 14) ? 2'b01 : 2'b00;
      n_cmp++;
      if (tick !== exp) begin n_err++; $display("FAIL load_mid_tick m=%0d got=%b want=%b", m, tick, exp); end
    end
    load_valid = 1'b0;
  endtask

  task automatic test_oneshot();
    logic [1:0] exp_t, exp_r;
    do_reset();
    en = 2'b10;
    for (int m = 0; m < 19; m++) begin
      load_valid  = (m == 0);
      load_ch     = 1'b1;
      load_period = 8'd4;
      load_mode   = 1'b1;
      start       = (m == 1 || m == 9 || m == 12) ? 2'b10 : 2'b00;
      cyc();
      exp_t = (m == 5 || m == 16) ? 2'b10 : 2'b00;
      exp_r = ((m >= 1 && m <= 4) || (m >= 9 && m <= 15)) ? 2'b10 : 2'b00;
      n_cmp++;
      if (tick !== exp_t) begin n_err++; $display("FAIL oneshot_tick m=%0d got=%b want=%b", m, tick, exp_t); end
      n_cmp++;
      if (running !== exp_r) begin n_err++; $display("FAIL oneshot_running m=%0d got=%b want=%b", m, running, exp_r); end
    end
    load_valid = 1'b0;
    start      = 2'b00;
  endtask

  task automatic test_sync();
    logic [1:0] exp;
    do_reset();
    en = 2'b11;
    for (int m = 0; m < 17; m++) begin
      sync = (m == 5);
      cyc();
      exp = (m == 10 || m == 15) ? 2'b11 : 2'b00;
      n_cmp++;
      if (tick !== exp) begin n_err++; $display("FAIL sync_tick m=%0d got=%b want=%b", m, tick, exp); end
      n_cmp++;
      if (running !== 2'b11) begin n_err++; $display("FAIL sync_running m=%0d got=%b want=11", m, running); end
    end
    sync = 1'b0;
  endtask

  task automatic test_period_edges();
    logic [1:0] exp_t, exp_r;
    do_reset();
    for (int m = 0; m < 16; m++) begin
      load_valid  = (m == 0 || m == 9);
      load_ch     = 1'b0;
      load_period = (m == 0) ? 8'd0 : 8'd1;
      load_mode   = 1'b0;
      en          = (m == 0 || m == 9) ? 2'b00 : 2'b01;
      cyc();
      exp_t = (m >= 11) ? 2'b01 : 2'b00;
      exp_r = (m >= 10) ? 2'b01 : 2'b00;
      n_cmp++;
      if (tick !== exp_t) begin n_err++; $display("FAIL p0p1_tick m=%0d got=%b want=%b", m, tick, exp_t); end
      n_cmp++;
      if (running !== exp_r) begin n_err++; $display("FAIL p0p1_running m=%0d got=%b want=%b", m, running, exp_r); end
    end
    load_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [1:0] exp;
    do_reset();
    en = 2'b11;
    for (int m = 0; m < 4; m++) begin
      load_valid  = (m == 0);
      load_ch     = 1'b1;
      load_period = 8'd7;
      load_mode   = 1'b0;
      cyc();
    end
    load_valid = 1'b0;
    n_cmp++;
    if (running !== 2'b11) begin n_err++; $display("FAIL areset_pre_running got=%b want=11", running); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (running !== 2'b00 || tick !== 2'b00) begin
      n_err++; $display("FAIL areset_async tick=%b running=%b want 00/00", tick, running);
    end
    cyc();
    n_cmp++;
    if (running !== 2'b00 || tick !== 2'b00) begin
      n_err++; $display("FAIL areset_held tick=%b running=%b want 00/00", tick, running);
    end
    reset = 1'b0;
    for (int m = 0; m < 7; m++) begin
      cyc();
      exp = (m == 5) ? 2'b11 : 2'b00;
      n_cmp++;
      if (tick !== exp) begin n_err++; $display("FAIL areset_restart_tick m=%0d got=%b want=%b", m, tick, exp); end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_periodic();
    test_load_midperiod();
    test_oneshot();
    test_sync();
    test_period_edges();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
